// File: rtl/serial_byte_rx.sv
// Asynchronous serial byte receiver: idle-high line, start bit, 8 data bits LSB first, stop bit.
// Optional even-parity bit between the data and stop bits when SERIAL_BYTE_RX_PARITY_EN is defined.
module serial_byte_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input  logic       C,
   input  logic       Reset,
   input  logic       RxD,
   output logic [7:0] PO,
   output logic       Valid,
   output logic       FrameErr,
   output logic       ParErr,
   output logic       Busy
);

   // state     | meaning
   // IDLE      | line idle, waiting for a low level
   // START     | half a bit period, confirm the start bit at its centre
   // DATA      | eight full bit periods, sample each data bit at its centre
   // PARITY    | one bit period, sample the even-parity bit (parity build only)
   // STOP      | one bit period, sample the stop bit and issue strobes
   // WAIT_HIGH | after a framing error, wait for the line to return high
   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, WAIT_HIGH
`ifdef SERIAL_BYTE_RX_PARITY_EN
      , PARITY
`endif
   } state_t;

   localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t           state, state_nxt;
   logic             sync1, rx_s;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       sh, sh_nxt;
   logic [7:0]       po_nxt;
   logic             valid_nxt, ferr_nxt;

`ifdef SERIAL_BYTE_RX_PARITY_EN
   logic par_bad, par_bad_nxt;
   logic perr_q, perr_nxt;
   assign ParErr = perr_q;
`else
   assign ParErr = 1'b0;
`endif

   assign Busy = (state != IDLE);

   always_ff @(posedge C or posedge Reset) begin
      if (Reset) begin
         sync1    <= 1'b1;
         rx_s     <= 1'b1;
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         sh       <= '0;
         PO       <= '0;
         Valid    <= 1'b0;
         FrameErr <= 1'b0;
`ifdef SERIAL_BYTE_RX_PARITY_EN
         par_bad  <= 1'b0;
         perr_q   <= 1'b0;
`endif
      end else begin
         sync1    <= RxD;
         rx_s     <= sync1;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         idx      <= idx_nxt;
         sh       <= sh_nxt;
         PO       <= po_nxt;
         Valid    <= valid_nxt;
         FrameErr <= ferr_nxt;
`ifdef SERIAL_BYTE_RX_PARITY_EN
         par_bad  <= par_bad_nxt;
         perr_q   <= perr_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      sh_nxt    = sh;
      po_nxt    = PO;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
`ifdef SERIAL_BYTE_RX_PARITY_EN
      par_bad_nxt = par_bad;
      perr_nxt    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nxt = START;
               cnt_nxt   = '0;
            end
         end
         START: begin
            if (cnt == HALF_TC) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  state_nxt = DATA;
                  idx_nxt   = '0;
`ifdef SERIAL_BYTE_RX_PARITY_EN
                  par_bad_nxt = 1'b0;
`endif
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         DATA: begin
            if (cnt == FULL_TC) begin
               cnt_nxt = '0;
               sh_nxt  = {rx_s, sh[7:1]};
               idx_nxt = idx + 3'd1;
               if (idx == 3'd7) begin
`ifdef SERIAL_BYTE_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
`ifdef SERIAL_BYTE_RX_PARITY_EN
         PARITY: begin
            if (cnt == FULL_TC) begin
               cnt_nxt     = '0;
               par_bad_nxt = rx_s ^ (^sh);
               state_nxt   = STOP;
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
`endif
         STOP: begin
            if (cnt == FULL_TC) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  state_nxt = IDLE;
`ifdef SERIAL_BYTE_RX_PARITY_EN
                  if (par_bad) begin
                     perr_nxt = 1'b1;
                  end else begin
                     valid_nxt = 1'b1;
                     po_nxt    = sh;
                  end
`else
                  valid_nxt = 1'b1;
                  po_nxt    = sh;
`endif
               end else begin
                  // Framing error: park until the line recovers so a break gives one strobe
                  state_nxt = WAIT_HIGH;
                  ferr_nxt  = 1'b1;
`ifdef SERIAL_BYTE_RX_PARITY_EN
                  perr_nxt  = par_bad;
`endif
               end
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         WAIT_HIGH: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed self-checking bench for serial_byte_rx at CLKS_PER_BIT=16; follows the parity build
// when SERIAL_BYTE_RX_PARITY_EN is defined.
module tb_serial_byte_rx;

   localparam int CPB = 16;
`ifdef SERIAL_BYTE_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int LAT   = 2 + CPB / 2 + 9 * CPB + PAR_BITS * CPB;
   localparam int FRAME = (10 + PAR_BITS) * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic [7:0] po;
   logic       valid, frame_err, par_err, busy;

   int tests_run = 0;
   int fails     = 0;
   int cyc       = 0;
   int t0        = 0;

   int         v_n = 0, fe_n = 0, pe_n = 0, dbl_n = 0;
   int         v_cyc [8];
   logic [7:0] v_po [8];
   logic       v_busy [8];
   logic       v_busy_prev [8];
   logic       valid_prev = 1'b0, fe_prev = 1'b0, pe_prev = 1'b0, busy_prev = 1'b0;

   serial_byte_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .C       (clk),
      .Reset   (rst),
      .RxD     (rxd),
      .PO      (po),
      .Valid   (valid),
      .FrameErr(frame_err),
      .ParErr  (par_err),
      .Busy    (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Strobe monitor sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (valid) begin
         if (v_n < 8) begin
            v_cyc[v_n]       = cyc;
            v_po[v_n]        = po;
            v_busy[v_n]      = busy;
            v_busy_prev[v_n] = busy_prev;
         end
         v_n = v_n + 1;
      end
      if (frame_err) fe_n = fe_n + 1;
      if (par_err)   pe_n = pe_n + 1;
      if ((valid && valid_prev) || (frame_err && fe_prev) || (par_err && pe_prev)) dbl_n = dbl_n + 1;
      valid_prev = valid;
      fe_prev    = frame_err;
      pe_prev    = par_err;
      busy_prev  = busy;
   end

   task automatic clear_counts();
      v_n = 0; fe_n = 0; pe_n = 0;
   endtask

   task automatic drive_bit(input logic b);
      rxd = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
      t0 = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (PAR_BITS == 1) drive_bit(par_b);
      drive_bit(stop_b);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      clear_counts();
      repeat (100) @(negedge clk);
      tests_run++; if (po !== 8'h00) begin fails++; $display("FAIL reset_po got=%h exp=00", po); end
      tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      tests_run++; if ({valid, frame_err, par_err} !== 3'b000) begin fails++; $display("FAIL reset_strobes got=%b exp=000", {valid, frame_err, par_err}); end
      tests_run++; if (v_n + fe_n + pe_n !== 0) begin fails++; $display("FAIL reset_idle_strobes got=%0d exp=0", v_n + fe_n + pe_n); end
   endtask

   task automatic test_byte();
      clear_counts();
      send_frame(8'hA5, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      tests_run++; if (v_n !== 1) begin fails++; $display("FAIL byte_valid_count got=%0d exp=1", v_n); end
      tests_run++; if (v_cyc[0] - t0 - 1 !== LAT) begin fails++; $display("FAIL byte_latency got=%0d exp=%0d", v_cyc[0] - t0 - 1, LAT); end
      tests_run++; if (v_po[0] !== 8'hA5) begin fails++; $display("FAIL byte_po_at_valid got=%h exp=a5", v_po[0]); end
      tests_run++; if ({v_busy_prev[0], v_busy[0]} !== 2'b10) begin fails++; $display("FAIL byte_busy_fall got=%b exp=10", {v_busy_prev[0], v_busy[0]}); end
      tests_run++; if (po !== 8'hA5) begin fails++; $display("FAIL byte_po_hold got=%h exp=a5", po); end
      tests_run++; if (fe_n + pe_n !== 0) begin fails++; $display("FAIL byte_err_strobes got=%0d exp=0", fe_n + pe_n); end
   endtask

   task automatic test_glitch();
      clear_counts();
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
      tests_run++; if (v_n + fe_n + pe_n !== 0) begin fails++; $display("FAIL glitch_strobes got=%0d exp=0", v_n + fe_n + pe_n); end
      tests_run++; if (po !== 8'hA5) begin fails++; $display("FAIL glitch_po got=%h exp=a5", po); end
   endtask

   task automatic test_frame_err();
      clear_counts();
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (50 * CPB) @(negedge clk);
      tests_run++; if (fe_n !== 1) begin fails++; $display("FAIL ferr_count got=%0d exp=1", fe_n); end
      tests_run++; if (v_n !== 0) begin fails++; $display("FAIL ferr_valid got=%0d exp=0", v_n); end
      tests_run++; if (pe_n !== 0) begin fails++; $display("FAIL ferr_parerr got=%0d exp=0", pe_n); end
      tests_run++; if (po !== 8'hA5) begin fails++; $display("FAIL ferr_po got=%h exp=a5", po); end
      tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL ferr_wait_high got=%b exp=1", busy); end
      rxd = 1'b1;
      repeat (5) @(negedge clk);
      tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_release got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      send_frame(8'h01, 1'b1, 1'b1);
      send_frame(8'hFE, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      tests_run++; if (v_n !== 2) begin fails++; $display("FAIL b2b_valid_count got=%0d exp=2", v_n); end
      tests_run++; if (v_cyc[1] - v_cyc[0] !== FRAME) begin fails++; $display("FAIL b2b_spacing got=%0d exp=%0d", v_cyc[1] - v_cyc[0], FRAME); end
      tests_run++; if (v_po[0] !== 8'h01) begin fails++; $display("FAIL b2b_first got=%h exp=01", v_po[0]); end
      tests_run++; if (v_po[1] !== 8'hFE) begin fails++; $display("FAIL b2b_second got=%h exp=fe", v_po[1]); end
      tests_run++; if (fe_n + pe_n !== 0) begin fails++; $display("FAIL b2b_err_strobes got=%0d exp=0", fe_n + pe_n); end
      tests_run++; if (dbl_n !== 0) begin fails++; $display("FAIL strobe_double got=%0d exp=0", dbl_n); end
   endtask

   task automatic test_parity();
      clear_counts();
      send_frame(8'h07, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      tests_run++; if (pe_n !== 1) begin fails++; $display("FAIL parity_perr got=%0d exp=1", pe_n); end
      tests_run++; if (v_n !== 0) begin fails++; $display("FAIL parity_valid got=%0d exp=0", v_n); end
      tests_run++; if (fe_n !== 0) begin fails++; $display("FAIL parity_ferr got=%0d exp=0", fe_n); end
      tests_run++; if (po !== 8'hFE) begin fails++; $display("FAIL parity_po got=%h exp=fe", po); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      clear_counts();
      d  = 8'h5A;
      t0 = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      rxd = d[4];
      repeat (4) @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      tests_run++; if (po !== 8'h00) begin fails++; $display("FAIL midrst_po got=%h exp=00", po); end
      tests_run++; if ({valid, frame_err, par_err, busy} !== 4'b0000) begin fails++; $display("FAIL midrst_flags got=%b exp=0000", {valid, frame_err, par_err, busy}); end
      @(negedge clk);
      rxd = 1'b1;
      rst = 1'b0;
      repeat (200) @(negedge clk);
      tests_run++; if (v_n + fe_n + pe_n !== 0) begin fails++; $display("FAIL midrst_strobes got=%0d exp=0", v_n + fe_n + pe_n); end
      tests_run++; if (po !== 8'h00) begin fails++; $display("FAIL midrst_po_after got=%h exp=00", po); end
   endtask

   initial begin
      test_reset();
      test_byte();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      if (PAR_BITS == 1) test_parity();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/serial_byte_rx.md
Name: serial_byte_rx

Overview:
- Downstream stage of the 8-bit right-shifting serial shift register.
- Consumes its SO stream, which sends LSB first, as an asynchronous serial line: idle high, start bit 0, 8 data bits, optional parity, stop bit 1.
- Recovers bit timing from a local clock, reassembles the byte, and presents it in parallel with a one-cycle valid strobe and error flags.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit period; legal range 4..65535, even values only.
- CNT_W, 16: width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- C  input  1  clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- RxD  input  1  serial line (fed from the shift register's SO); asynchronous to C.
- PO  output  8  last correctly received byte.
- Valid  output  1  one-cycle strobe; PO updated in the same cycle.
- FrameErr  output  1  one-cycle strobe when the stop bit is sampled as 0.
- ParErr  output  1  one-cycle strobe on parity mismatch (see Optional Feature).
- Busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: PO=0, Valid=0, FrameErr=0, ParErr=0, Busy=0. Synchroniser flops=1. FSM=IDLE. Counter=0. Bit index=0. Shift register=0.
- Input sync: 2-flop synchroniser on RxD; all FSM decisions use the synchronised value rx_s.
- FSM states: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP, WAIT_HIGH.
- IDLE:
  - rx_s==0 -> START, counter cleared.
- START:
  - Counter runs 0..CLKS_PER_BIT/2-1.
  - At the terminal count, sample rx_s. If 0 -> DATA, counter=0, bit index=0. If 1 -> glitch rejected, return to IDLE with no strobes.
- DATA:
  - Counter runs 0..CLKS_PER_BIT-1.
  - At the terminal count, shift the sample in MSB-side: sh <= {rx_s, sh[7:1]}. The first received bit therefore lands in PO[0].
  - Bit index increments per sample. After the sample taken at index 7 -> PARITY if enabled, else STOP.
- STOP:
  - Full bit period, then sample rx_s.
  - Sample 1 and no parity error -> Valid=1 for one cycle, PO<=sh, go IDLE.
  - Sample 0 -> FrameErr=1 for one cycle, PO unchanged, Valid=0, go WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then go IDLE. A held-low line (break) never produces repeated FrameErr.
- Strobes: Valid, FrameErr and ParErr are never high for two consecutive cycles. At most one of them is high in any cycle, except that FrameErr and ParErr are both asserted when both errors occur.
- Latency: Valid rises (2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT) cycles after the first C edge that sees RxD low. With PARITY_EN, add CLKS_PER_BIT.
- Back-to-back frames: a start bit immediately after the stop sample is accepted. IDLE detects the falling edge in the next cycle; no dead time beyond one cycle.
- Reset mid-frame: all state returns to reset values immediately. The partial byte is discarded and no strobe is produced.
- PO holds its value indefinitely between Valid strobes. There is no downstream back-pressure; the consumer must capture PO on Valid.

Optional Feature:
- Macro: SERIAL_BYTE_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and lasts one bit period.
  - The sampled bit must equal the XOR of the 8 data bits (even parity).
  - On mismatch, ParErr strobes in the STOP sample cycle and Valid is suppressed; PO is unchanged.
  - The stop bit is still checked; FrameErr behaves as above.
- Undefined:
  - No PARITY state; the frame is 10 bits.
  - ParErr is tied to 0.
  - The port list is identical in both builds.

Test Plan:
- Reset, RxD=1 idle for 100 cycles -> PO=0, Valid/FrameErr/ParErr/Busy all 0.
- CLKS_PER_BIT=16, send 0xA5 LSB first with valid stop -> single Valid pulse at cycle 2+8+144=154 after the start edge, PO=0xA5, Busy falls with Valid.
- 4-cycle low glitch on idle RxD -> START rejects it, returns to IDLE; no strobes, PO unchanged.
- Send 0x3C with stop bit forced 0, then hold RxD low for 50 bit periods -> exactly one FrameErr pulse, PO keeps the previous value, FSM in WAIT_HIGH until RxD=1.
- Two back-to-back frames 0x01, 0xFE with no idle gap -> two Valid pulses 160 cycles apart, PO=0x01 then 0xFE.
- Reset asserted mid-DATA after bit 3 -> all outputs 0 immediately. With PARITY_EN, send 0x07 with parity bit 0 -> ParErr pulse, no Valid.
